// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit for the execute stage. Runs MULTU/MULT/DIVU/DIV
// as one shift-add or restoring shift-subtract step per clock into private
// HI/LO registers. It also services MTHI/MTLO moves, and can be flushed by ABORT.
//
// Ports:
//   CLK    - system clock, rising edge
//   RST_N  - asynchronous active-low reset
//   START  - one-cycle request to begin an operation (taken only when idle)
//   OP     - 00=MULTU, 01=MULT, 10=DIVU, 11=DIV (sampled with START)
//   OPA    - rs operand (multiplicand / dividend, MTHI/MTLO data)
//   OPB    - rt operand (multiplier / divisor)
//   MTHI   - write OPA into HI (idle, no START)
//   MTLO   - write OPA into LO (idle, no START)
//   ABORT  - pipeline flush; cancels the in-flight operation
//   HI, LO - result registers (product high/low, remainder/quotient)
//   BUSY   - operation in progress
//   DONE   - one-cycle pulse when HI/LO receive a result
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic             ABORT,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's complement negation helpers.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;     // |A|: multiplicand, or dividend for the /0 case
    logic [WIDTH-1:0] mag_b_q, mag_b_d;     // |B|: divisor
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] mag_opa_s;
    logic [WIDTH-1:0] mag_opb_s;
    logic             opa_neg_s;
    logic             opb_neg_s;

    // One iteration of the multiply and divide datapaths, plus operand magnitudes.
    always_comb begin
        opa_neg_s = OP[0] & OPA[WIDTH-1];
        opb_neg_s = OP[0] & OPB[WIDTH-1];
        mag_opa_s = opa_neg_s ? neg_w(OPA) : OPA;
        mag_opb_s = opb_neg_s ? neg_w(OPB) : OPB;

        // Shift-add: the carry out of the add becomes the new top bit after the shift.
        mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});

        // Restoring divide: partial remainder is always < divisor, so the
        // subtraction result fits in WIDTH bits when it is taken.
        div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mag_b_q});
        div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - mag_b_q) : div_shift_s[WIDTH-1:0];
    end

    // Next-state, datapath and output logic of the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    is_div_d = OP[1];
                    sign_a_d = opa_neg_s;
                    sign_b_d = opb_neg_s;
                    mag_a_d  = mag_opa_s;
                    mag_b_d  = mag_opb_s;
                    acc_hi_d = {WIDTH{1'b0}};
                    // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                    acc_lo_d = OP[1] ? mag_opa_s : mag_opb_s;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    // Moves are only honoured when no operation is being started.
                    if (MTHI) begin
                        hi_d = OPA;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (MTLO) begin
                        lo_d = OPA;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end

            ST_RUN: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_rem_s;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_s};
                    end else begin
                        acc_hi_d = mul_sum_s[WIDTH:1];
                        acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_FIX: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q && (mag_b_q == {WIDTH{1'b0}})) begin
                        // Divide by zero returns all-ones and the original dividend.
                        lo_d = {WIDTH{1'b1}};
                        hi_d = sign_a_q ? neg_w(mag_a_q) : mag_a_q;
                    end else if (is_div_q) begin
                        lo_d = (sign_a_q ^ sign_b_q) ? neg_w(acc_lo_q) : acc_lo_q;
                        hi_d = sign_a_q ? neg_w(acc_hi_q) : acc_hi_q;
                    end else begin
                        {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? neg_2w({acc_hi_q, acc_lo_q})
                                                             : {acc_hi_q, acc_lo_q};
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= {WIDTH{1'b0}};
            mag_b_q  <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32). Expected HI/LO come from a
// 64-bit arithmetic reference model; inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] OPA;
    logic [31:0] OPB;
    logic        MTHI;
    logic        MTLO;
    logic        ABORT;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .OP    (OP),
        .OPA   (OPA),
        .OPB   (OPB),
        .MTHI  (MTHI),
        .MTLO  (MTLO),
        .ABORT (ABORT),
        .HI    (HI),
        .LO    (LO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: returns {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                u = {32'd0, a} * {32'd0, b};
                return u;
            end
            2'b01: begin
                r = sa * sb;
                return r;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                u[31:0]  = 32'(sa / sb);
                u[63:32] = 32'(sa % sb);
                return u;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation and wait (bounded) for DONE; reports what was observed.
    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit busy_ok, output bit busy_at_done,
                            output logic [31:0] hi, output logic [31:0] lo, output bit done_after);
        @(negedge CLK);
        START = 1'b1; OP = op; OPA = a; OPB = b;
        @(negedge CLK);
        START = 1'b0; OPA = $urandom; OPB = $urandom;
        busy_ok = BUSY;
        lat = -1;
        busy_at_done = 1'b1;
        hi = HI; lo = LO;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = i;
                busy_at_done = BUSY;
                hi = HI; lo = LO;
                break;
            end
            if (!BUSY) busy_ok = 1'b0;
        end
        @(negedge CLK);
        done_after = DONE;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        if ({HI, LO, BUSY, DONE} !== 66'd0) begin
            errors++; $display("FAIL reset_hold got HI=%h LO=%h BUSY=%b DONE=%b want zeros", HI, LO, BUSY, DONE);
        end
        checks++;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        if ({HI, LO, BUSY, DONE} !== 66'd0) begin
            errors++; $display("FAIL reset_idle got HI=%h LO=%h BUSY=%b DONE=%b want zeros", HI, LO, BUSY, DONE);
        end
        checks++;
    endtask

    task automatic test_moves();
        MTHI = 1'b1; OPA = 32'h0000_ABCD;
        @(negedge CLK);
        MTHI = 1'b0;
        if (HI !== 32'h0000_ABCD || LO !== 32'd0) begin
            errors++; $display("FAIL mthi got HI=%h LO=%h want 0000abcd 00000000", HI, LO);
        end
        checks++;
        MTLO = 1'b1; OPA = 32'h0000_1234;
        @(negedge CLK);
        MTLO = 1'b0;
        if (LO !== 32'h0000_1234 || HI !== 32'h0000_ABCD) begin
            errors++; $display("FAIL mtlo got HI=%h LO=%h want 0000abcd 00001234", HI, LO);
        end
        checks++;
        MTHI = 1'b1; MTLO = 1'b1; OPA = 32'h5A5A_0F0F;
        @(negedge CLK);
        MTHI = 1'b0; MTLO = 1'b0;
        if (HI !== 32'h5A5A_0F0F || LO !== 32'h5A5A_0F0F) begin
            errors++; $display("FAIL mt_both got HI=%h LO=%h want 5a5a0f0f x2", HI, LO);
        end
        checks++;
    endtask

    task automatic test_ops(input int n_random);
        logic [1:0]  ops [7];
        logic [31:0] as  [7];
        logic [31:0] bs  [7];
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int lat;
        bit busy_ok, busy_at_done, done_after;
        ops = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        bs  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        for (int i = 0; i < 7 + n_random; i++) begin
            if (i < 7) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand();
            end
            exp = model(op, a, b);
            drive_op(op, a, b, lat, busy_ok, busy_at_done, hi, lo, done_after);
            if (lat !== 33 || !busy_ok || busy_at_done || done_after) begin
                errors++; $display("FAIL timing op=%0d a=%h b=%h got lat=%0d busy_ok=%b busy@done=%b done_after=%b want 33 1 0 0",
                                   op, a, b, lat, busy_ok, busy_at_done, done_after);
            end
            checks++;
            if ({hi, lo} !== exp) begin
                errors++; $display("FAIL result op=%0d a=%h b=%h got HI=%h LO=%h want HI=%h LO=%h",
                                   op, a, b, hi, lo, exp[63:32], exp[31:0]);
            end
            checks++;
        end
    endtask

    task automatic test_busy_ignore();
        bit seen;
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; OPA = 32'd5; OPB = 32'd6;
        @(negedge CLK);
        START = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin START = 1'b1; OP = 2'b10; OPA = 32'd100; OPB = 32'd7; end
            if (i == 6) START = 1'b0;
            if (i == 8) begin MTLO = 1'b1; MTHI = 1'b1; OPA = 32'hDEAD_0001; end
            if (i == 9) begin MTLO = 1'b0; MTHI = 1'b0; end
            @(negedge CLK);
            if (DONE) begin seen = 1'b1; break; end
        end
        if (!seen || HI !== 32'd0 || LO !== 32'd30) begin
            errors++; $display("FAIL busy_ignore got done=%b HI=%h LO=%h want 1 00000000 0000001e", seen, HI, LO);
        end
        checks++;
        @(negedge CLK);
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL no_requeue got BUSY=%b want 0", BUSY);
        end
        checks++;
    endtask

    // ABORT_AT is the negedge index (after accept) at which ABORT is raised for one edge.
    task automatic test_abort(input int abort_at);
        bit seen;
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; OPA = 32'd7; OPB = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 1; i < abort_at; i++) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL abort_%0d got BUSY=%b DONE=%b want 0 0", abort_at, BUSY, DONE);
        end
        checks++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) seen = 1'b1;
        end
        if (seen || HI !== 32'd0 || LO !== 32'd30) begin
            errors++; $display("FAIL abort_keep_%0d got activity=%b HI=%h LO=%h want 0 00000000 0000001e", abort_at, seen, HI, LO);
        end
        checks++;
    endtask

    task automatic test_idle_priority();
        @(negedge CLK);
        START = 1'b1; ABORT = 1'b1; OP = 2'b00; OPA = 32'd2; OPB = 32'd2;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL abort_start_idle got BUSY=%b want 0", BUSY);
        end
        checks++;
        START = 1'b1; MTHI = 1'b1; MTLO = 1'b1; OP = 2'b00; OPA = 32'd11; OPB = 32'd3;
        @(negedge CLK);
        START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        if (BUSY !== 1'b1 || HI !== 32'd0 || LO !== 32'd30) begin
            errors++; $display("FAIL start_beats_mt got BUSY=%b HI=%h LO=%h want 1 00000000 0000001e", BUSY, HI, LO);
        end
        checks++;
        for (int i = 0; i < 40 && !DONE; i++) @(negedge CLK);
        if (DONE !== 1'b1 || LO !== 32'd33 || HI !== 32'd0) begin
            errors++; $display("FAIL start_beats_mt_result got DONE=%b HI=%h LO=%h want 1 00000000 00000021", DONE, HI, LO);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        logic [31:0] hi, lo;
        int lat;
        bit busy_ok, busy_at_done, done_after;
        @(negedge CLK);
        MTHI = 1'b1; OPA = 32'hCAFE_F00D;
        @(negedge CLK);
        MTHI = 1'b0;
        START = 1'b1; OP = 2'b11; OPA = 32'h7FFF_FFFF; OPB = 32'd3;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        if (HI !== 32'd0 || LO !== 32'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL async_reset got HI=%h LO=%h BUSY=%b DONE=%b want zeros", HI, LO, BUSY, DONE);
        end
        checks++;
        @(negedge CLK);
        RST_N = 1'b1;
        drive_op(2'b00, 32'd3, 32'd4, lat, busy_ok, busy_at_done, hi, lo, done_after);
        if (lat !== 33 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++; $display("FAIL post_reset_mul got lat=%0d HI=%h LO=%h want 33 00000000 0000000c", lat, hi, lo);
        end
        checks++;
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; OP = 2'b00; OPA = 32'd0; OPB = 32'd0;
        MTHI = 1'b0; MTLO = 1'b0; ABORT = 1'b0;
        test_reset();
        test_moves();
        test_ops(24);
        test_busy_ignore();
        test_abort(10);
        test_abort(33);
        test_idle_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two registered read-port operands (rs, rt) and executes MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers.
- Also services MTHI/MTLO writes; HI/LO are read by MFHI/MFLO through the writeback mux.
- Control asserts BUSY-based stalls.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle request to begin an operation (sampled only when idle).
- OP  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; sampled with START.
- OPA  input  WIDTH  rs operand (multiplicand / dividend).
- OPB  input  WIDTH  rt operand (multiplier / divisor).
- MTHI  input  1  write OPA into HI.
- MTLO  input  1  write OPA into LO.
- ABORT  input  1  pipeline flush; cancels the in-flight operation.
- HI  output  WIDTH  HI register (product high / remainder).
- LO  output  WIDTH  LO register (product low / quotient).
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse when HI/LO receive a result.

Behaviour:
- Reset (RST_N=0, async, any time including mid-operation):
  - HI=0, LO=0, BUSY=0, DONE=0, FSM=IDLE, iteration counter=0, internal accumulators cleared.
  - Resumes on the first CLK edge after RST_N rises.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on edge with START=1 → latch OP, |OPA|, |OPB| (magnitudes for signed ops, raw for unsigned) and the result-sign flags; counter=0; go to RUN; BUSY=1 from this edge.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter increments. When counter reaches WIDTH-1 (the WIDTH-th step), go to FIX.
  - FIX: apply sign correction, write HI/LO, BUSY=0, DONE=1 for exactly one cycle; go to IDLE.
- Latency: START accepted at edge E0; HI/LO valid and DONE=1 after edge E0+WIDTH+1 (33 edges for WIDTH=32). BUSY is high for WIDTH+1 cycles.
- Multiply: 2*WIDTH-bit product. Signed product is negated when sign(A) xor sign(B). HI=product[2W-1:W], LO=product[W-1:0].
- Divide:
  - LO=quotient, HI=remainder.
  - Signed: quotient negated when sign(A) xor sign(B); remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of magnitude arithmetic, no trap).
- Divide by zero (OPB=0, signed or unsigned): completes in the normal latency with LO=all-ones, HI=OPA (original, unsigned view). DONE still pulses.
- START while BUSY: ignored, no queueing.
- MTHI/MTLO:
  - Honoured only in IDLE with START=0; the register updates on that edge with zero latency.
  - Both asserted together: both written from OPA.
  - Ignored while BUSY.
  - START together with MTHI/MTLO in IDLE: START wins and the moves are dropped.
- ABORT:
  - In RUN or FIX: next edge → IDLE, BUSY=0, DONE=0, HI/LO unchanged.
  - ABORT together with START in IDLE: START is not accepted.
  - ABORT has priority over DONE generation.
- HI/LO change only on a FIX edge, an accepted MTHI/MTLO, or reset.

Test Plan:
1. Reset then idle → HI=0, LO=0, BUSY=0, DONE=0. MTHI with OPA=0x0000ABCD → HI=0x0000ABCD next edge; MTLO with OPA=0x1234 → LO=0x00001234.
2. MULTU, OPA=OPB=0xFFFFFFFF → BUSY for 33 cycles; DONE pulses once; HI=0xFFFFFFFE, LO=0x00000001. MULT, OPA=0xFFFFFFFD (-3), OPB=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. DIVU 7/2 → LO=3, HI=1. DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIV, OPA=0x12345678, OPB=0 → after 33 cycles LO=0xFFFFFFFF, HI=0x12345678, DONE=1.
5. MULTU 5*6 in flight:
   - Second START (OP=DIVU) at cycle 5 → ignored; result HI=0, LO=30.
   - Repeat with ABORT at cycle 10 → BUSY=0 next cycle, no DONE, HI/LO keep prior values.
   - MTLO during BUSY → no effect.
6. RST_N pulsed low at cycle 15 of a DIV → HI=LO=0 and BUSY=0 immediately (asynchronous). A fresh MULTU 3*4 afterwards → LO=12, HI=0.
